// File: rtl/execute_stage_if.sv
// Bundle between the decode/execute latch, the execute stage and the
// execute/memory latch outputs that feed the memory stage.
interface execute_stage_if;
  logic        ihit;
  logic        dhit;
  logic        flush;
  logic [3:0]  ALUOp;
  logic [31:0] portA;
  logic [31:0] portB;
  logic [31:0] storeData;
  logic        dREN;
  logic        dWEN;
  logic        regWr;
  logic [1:0]  regSel;
  logic [4:0]  regDst;
  logic [31:0] nPC;

  logic        busy;
  logic        overflow;
  logic        dREN_next;
  logic        dWEN_next;
  logic        regWr_next;
  logic [1:0]  regSel_next;
  logic [4:0]  regDst_next;
  logic [31:0] nPC_next;
  logic [31:0] ALUOut_next;
  logic [31:0] storeData_next;

  modport master (
    output ihit, dhit, flush, ALUOp, portA, portB, storeData,
           dREN, dWEN, regWr, regSel, regDst, nPC,
    input  busy, overflow, dREN_next, dWEN_next, regWr_next,
           regSel_next, regDst_next, nPC_next, ALUOut_next, storeData_next
  );

  modport slave (
    input  ihit, dhit, flush, ALUOp, portA, portB, storeData,
           dREN, dWEN, regWr, regSel, regDst, nPC,
    output busy, overflow, dREN_next, dWEN_next, regWr_next,
           regSel_next, regDst_next, nPC_next, ALUOut_next, storeData_next
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU, 32-iteration shift-add multiplier, and the
// execute/memory pipeline latch with stall and bubble control.
module execute_stage (
  input  logic           CLK,
  input  logic           RST,
  execute_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRL  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_mcand;
  logic [63:0] r_acc;
  logic [31:0] r_mplier;
  logic [4:0]  r_count;

  logic        r_dren;
  logic        r_dwen;
  logic        r_regwr;
  logic [1:0]  r_regsel;
  logic [4:0]  r_regdst;
  logic [31:0] r_npc;
  logic [31:0] r_alu;
  logic [31:0] r_store;

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_alu;
  logic        w_ovf;
  logic        w_start;
  logic        w_load;

  assign w_sum  = bus.portA + bus.portB;
  assign w_diff = bus.portA - bus.portB;

  // Single-cycle ALU result; MUL and unused encodings yield zero here.
  always_comb begin
    w_alu = 32'd0;
    case (bus.ALUOp)
      OP_SLL:  w_alu = bus.portB << bus.portA[4:0];
      OP_SRL:  w_alu = bus.portB >> bus.portA[4:0];
      OP_ADD:  w_alu = w_sum;
      OP_SUB:  w_alu = w_diff;
      OP_AND:  w_alu = bus.portA & bus.portB;
      OP_OR:   w_alu = bus.portA | bus.portB;
      OP_XOR:  w_alu = bus.portA ^ bus.portB;
      OP_NOR:  w_alu = ~(bus.portA | bus.portB);
      OP_SLT:  w_alu = {31'd0, ($signed(bus.portA) < $signed(bus.portB))};
      OP_SLTU: w_alu = {31'd0, (bus.portA < bus.portB)};
      default: w_alu = 32'd0;
    endcase
  end

  // Signed overflow: operands agree in sign (after negating B for SUB) but the result does not.
  always_comb begin
    w_ovf = 1'b0;
    case (bus.ALUOp)
      OP_ADD:  w_ovf = (bus.portA[31] == bus.portB[31]) && (w_sum[31] != bus.portA[31]);
      OP_SUB:  w_ovf = (bus.portA[31] != bus.portB[31]) && (w_diff[31] != bus.portA[31]);
      default: w_ovf = 1'b0;
    endcase
  end

  // Next-state and latch-control decode; flush beats dhit beats ihit.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.flush) begin
          w_state_next = IDLE;
        end else if (bus.dhit) begin
          w_state_next = IDLE;
        end else if (bus.ihit) begin
          if (bus.ALUOp == OP_MUL) begin
            w_start      = 1'b1;
            w_state_next = MUL;
          end else begin
            w_load       = 1'b1;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      MUL: begin
        if (bus.flush) begin
          w_state_next = IDLE;
        end else if (r_count == 5'd31) begin
          w_state_next = DONE;
        end else begin
          w_state_next = MUL;
        end
      end
      DONE: begin
        if (bus.flush) begin
          w_state_next = IDLE;
        end else if (bus.dhit) begin
          w_state_next = DONE;
        end else if (bus.ihit) begin
          w_load       = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Shift-add multiplier; it runs every MUL edge independent of ihit/dhit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_acc    <= 64'd0;
      r_count  <= 5'd0;
    end else if (w_start) begin
      r_mcand  <= {32'd0, bus.portA};
      r_mplier <= bus.portB;
      r_acc    <= 64'd0;
      r_count  <= 5'd0;
    end else if (r_state == MUL) begin
      r_acc    <= r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      r_mcand  <= {r_mcand[62:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[31:1]};
      r_count  <= r_count + 5'd1;
    end else begin
      r_mcand  <= r_mcand;
      r_mplier <= r_mplier;
      r_acc    <= r_acc;
      r_count  <= r_count;
    end
  end

  // Execute/memory latch. A MUL start only zeroes the side-effecting controls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dren   <= 1'b0;
      r_dwen   <= 1'b0;
      r_regwr  <= 1'b0;
      r_regsel <= 2'd0;
      r_regdst <= 5'd0;
      r_npc    <= 32'd0;
      r_alu    <= 32'd0;
      r_store  <= 32'd0;
    end else if (bus.flush) begin
      r_dren   <= 1'b0;
      r_dwen   <= 1'b0;
      r_regwr  <= 1'b0;
      r_regsel <= 2'd0;
      r_regdst <= 5'd0;
      r_npc    <= 32'd0;
      r_alu    <= 32'd0;
      r_store  <= 32'd0;
    end else if (bus.dhit) begin
      r_dren   <= 1'b0;
      r_dwen   <= 1'b0;
    end else if (w_start) begin
      r_dren   <= 1'b0;
      r_dwen   <= 1'b0;
      r_regwr  <= 1'b0;
    end else if (w_load) begin
      r_dren   <= bus.dREN;
      r_dwen   <= bus.dWEN;
      r_regwr  <= bus.regWr;
      r_regsel <= bus.regSel;
      r_regdst <= bus.regDst;
      r_npc    <= bus.nPC;
      r_alu    <= (r_state == DONE) ? r_acc[31:0] : w_alu;
      r_store  <= bus.storeData;
    end else begin
      r_dren   <= r_dren;
      r_dwen   <= r_dwen;
    end
  end

  assign bus.busy = ((r_state == IDLE) && bus.ihit && (bus.ALUOp == OP_MUL) && !bus.flush)
                  || (r_state == MUL);
  assign bus.overflow       = w_ovf;
  assign bus.dREN_next      = r_dren;
  assign bus.dWEN_next      = r_dwen;
  assign bus.regWr_next     = r_regwr;
  assign bus.regSel_next    = r_regsel;
  assign bus.regDst_next    = r_regdst;
  assign bus.nPC_next       = r_npc;
  assign bus.ALUOut_next    = r_alu;
  assign bus.storeData_next = r_store;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed table, multiply/flush/dhit
// sequences, and randomized traffic against a cycle-level behavioural model.
module tb_execute_stage;

  logic CLK = 1'b0;
  logic RST;
  bit   clk_en = 1'b1;

  always #5 if (clk_en) CLK = ~CLK;

  execute_stage_if bus();

  execute_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: the latch contents plus a multiply countdown.
  logic        m_dren, m_dwen, m_regwr;
  logic [1:0]  m_regsel;
  logic [4:0]  m_regdst;
  logic [31:0] m_npc, m_alu, m_store, m_prod;
  int          m_left;
  bit          m_done;
  bit          last_busy;
  bit          last_ovf;

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    case (op)
      4'd0:    return b << a[4:0];
      4'd1:    return b >> a[4:0];
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~(a | b);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_ovf(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint r;
    if (op == 4'd2)      r = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'd3) r = longint'($signed(a)) - longint'($signed(b));
    else                 return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic bit m_busy();
    return (m_left > 0) ||
           (!m_done && bus.ihit && (bus.ALUOp == 4'd10) && !bus.flush);
  endfunction

  task automatic model_reset();
    m_dren = 1'b0; m_dwen = 1'b0; m_regwr = 1'b0; m_regsel = 2'd0;
    m_regdst = 5'd0; m_npc = 32'd0; m_alu = 32'd0; m_store = 32'd0;
    m_prod = 32'd0; m_left = 0; m_done = 1'b0;
  endtask

  task automatic model_latch(logic [31:0] res);
    m_dren = bus.dREN; m_dwen = bus.dWEN; m_regwr = bus.regWr;
    m_regsel = bus.regSel; m_regdst = bus.regDst; m_npc = bus.nPC;
    m_alu = res; m_store = bus.storeData;
  endtask

  // One clock edge of the pipeline as described by its rules.
  task automatic model_step();
    if (bus.flush) begin
      model_reset();
    end else if (m_left > 0) begin
      if (bus.dhit) begin
        m_dren = 1'b0; m_dwen = 1'b0;
      end
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (bus.dhit) begin
      m_dren = 1'b0; m_dwen = 1'b0;
    end else if (bus.ihit) begin
      if (m_done) begin
        model_latch(m_prod);
        m_done = 1'b0;
      end else if (bus.ALUOp == 4'd10) begin
        m_prod = ref_alu(4'd10, bus.portA, bus.portB);
        m_left = 32;
        m_regwr = 1'b0; m_dren = 1'b0; m_dwen = 1'b0;
      end else begin
        model_latch(ref_alu(bus.ALUOp, bus.portA, bus.portB));
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_regs(string name);
    logic [105:0] got, exp;
    got = {bus.dREN_next, bus.dWEN_next, bus.regWr_next, bus.regSel_next,
           bus.regDst_next, bus.nPC_next, bus.ALUOut_next, bus.storeData_next};
    exp = {m_dren, m_dwen, m_regwr, m_regsel, m_regdst, m_npc, m_alu, m_store};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s latch: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(string name);
    #1;
    last_busy = bus.busy;
    last_ovf  = bus.overflow;
    chk({name, " busy"}, {31'd0, bus.busy}, {31'd0, m_busy()});
    chk({name, " ovf"}, {31'd0, bus.overflow},
        {31'd0, ref_ovf(bus.ALUOp, bus.portA, bus.portB)});
    @(posedge CLK);
    model_step();
    #1;
    check_regs(name);
    @(negedge CLK);
  endtask

  task automatic set_idle();
    bus.ihit = 1'b0; bus.dhit = 1'b0; bus.flush = 1'b0; bus.ALUOp = 4'd0;
    bus.portA = 32'd0; bus.portB = 32'd0; bus.storeData = 32'd0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.regWr = 1'b0; bus.regSel = 2'd0;
    bus.regDst = 5'd0; bus.nPC = 32'd0;
  endtask

  task automatic run_mul(logic [31:0] a, logic [31:0] b, logic [31:0] exp, string name);
    int busy_cnt = 0;
    int wr_cnt = 0;
    bus.ALUOp = 4'd10; bus.portA = a; bus.portB = b; bus.regWr = 1'b1;
    bus.regDst = 5'd9; bus.ihit = 1'b1; bus.dhit = 1'b0; bus.flush = 1'b0;
    for (int k = 0; k < 34; k++) begin
      cycle(name);
      busy_cnt += int'(last_busy);
      if (k < 33) wr_cnt += int'(bus.regWr_next);
    end
    chk({name, " busy cycles"}, busy_cnt, 32'd33);
    chk({name, " bubble regWr"}, wr_cnt, 32'd0);
    chk({name, " product"}, bus.ALUOut_next, exp);
    chk({name, " regWr"}, {31'd0, bus.regWr_next}, 32'd1);
    chk({name, " regDst"}, {27'd0, bus.regDst_next}, 32'd9);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom % 4)
      0:       return 32'($urandom % 8);
      1:       return 32'hFFFF_FFFF - 32'($urandom % 8);
      2:       return 32'h8000_0000 ^ 32'($urandom % 8);
      default: return 32'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_alu;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
    tbl[1]  = '{4'd3,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
    tbl[2]  = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[3]  = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[4]  = '{4'd0,  32'h0000_0004, 32'h0000_0001, 32'h0000_0010, 1'b0};
    tbl[5]  = '{4'd1,  32'h0000_001F, 32'h8000_0000, 32'h0000_0001, 1'b0};
    tbl[6]  = '{4'd4,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0};
    tbl[7]  = '{4'd5,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0};
    tbl[8]  = '{4'd6,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0};
    tbl[9]  = '{4'd7,  32'hFFFF_0000, 32'h0000_00FF, 32'h0000_FF00, 1'b0};
    tbl[10] = '{4'd11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0};
    tbl[11] = '{4'd3,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
    tbl[12] = '{4'd0,  32'h0000_0023, 32'h0000_0001, 32'h0000_0008, 1'b0};

    set_idle();
    model_reset();
    RST = 1'b1;
    #2;
    check_regs("reset");
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Directed single-cycle operations.
    for (int i = 0; i < 13; i++) begin
      bus.ALUOp = tbl[i].op; bus.portA = tbl[i].a; bus.portB = tbl[i].b;
      bus.ihit = 1'b1; bus.regDst = 5'(i); bus.regWr = 1'(i % 2);
      bus.regSel = 2'(i % 4); bus.nPC = 32'(i * 4); bus.storeData = ~tbl[i].a;
      bus.dREN = 1'(i == 3); bus.dWEN = 1'(i == 5);
      cycle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d alu", i), bus.ALUOut_next, tbl[i].exp_alu);
      chk($sformatf("tbl%0d ovf", i), {31'd0, last_ovf}, {31'd0, tbl[i].exp_ovf});
    end

    // Multiplies, the second starting right after the first's result edge.
    run_mul(32'd3, 32'd5, 32'd15, "mul3x5");
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mulmax");

    // Flush part way through a multiply, then a plain ADD.
    bus.ALUOp = 4'd10; bus.portA = 32'd6; bus.portB = 32'd7; bus.ihit = 1'b1;
    bus.regWr = 1'b1; bus.nPC = 32'h40; bus.storeData = 32'h55;
    for (int k = 0; k < 10; k++) cycle("flushmul");
    bus.flush = 1'b1;
    cycle("flush");
    chk("flush alu", bus.ALUOut_next, 32'd0);
    chk("flush npc", bus.nPC_next, 32'd0);
    bus.flush = 1'b0; bus.ihit = 1'b0; bus.ALUOp = 4'd2;
    bus.portA = 32'd2; bus.portB = 32'd2;
    cycle("postflush");
    chk("postflush busy", {31'd0, last_busy}, 32'd0);
    bus.ihit = 1'b1;
    cycle("add2p2");
    chk("add2p2 alu", bus.ALUOut_next, 32'd4);

    // dhit during a multiply and dhit beating ihit in IDLE.
    bus.ALUOp = 4'd2; bus.portA = 32'h100; bus.portB = 32'h20; bus.dREN = 1'b1;
    cycle("load");
    chk("load dREN", {31'd0, bus.dREN_next}, 32'd1);
    bus.ALUOp = 4'd10; bus.portA = 32'd1234; bus.portB = 32'd5678;
    cycle("dhitmul E0");
    for (int k = 1; k <= 32; k++) begin
      bus.dhit = 1'b0;
      if (k >= 5 && k <= 8) bus.dhit = 1'b1;
      cycle("dhitmul");
    end
    chk("dhitmul dREN", {31'd0, bus.dREN_next}, 32'd0);
    bus.dhit = 1'b0;
    cycle("dhitmul E33");
    chk("dhitmul product", bus.ALUOut_next, 32'd7006652);
    chk("dhitmul dREN latched", {31'd0, bus.dREN_next}, 32'd1);
    bus.ALUOp = 4'd2; bus.portA = 32'd9; bus.portB = 32'd9; bus.dhit = 1'b1;
    cycle("dhitwins");
    chk("dhitwins alu hold", bus.ALUOut_next, 32'd7006652);
    chk("dhitwins dREN", {31'd0, bus.dREN_next}, 32'd0);
    bus.dhit = 1'b0;

    // Asynchronous reset mid-multiply with the clock stopped.
    bus.ALUOp = 4'd10; bus.portA = 32'd77; bus.portB = 32'd3;
    for (int k = 0; k < 5; k++) cycle("premul");
    bus.ihit = 1'b0;
    clk_en = 1'b0;
    #12;
    RST = 1'b1;
    #1;
    model_reset();
    check_regs("async reset");
    chk("async reset busy", {31'd0, bus.busy}, 32'd0);
    RST = 1'b0;
    bus.ALUOp = 4'd0;
    #2;
    clk_en = 1'b1;
    @(negedge CLK);

    // Randomized traffic; operands and controls hold while a multiply is pending.
    for (int n = 0; n < 3000; n++) begin
      if (m_left == 0 && !m_done) begin
        bus.ALUOp = ($urandom % 8 == 0) ? 4'd10 : 4'($urandom % 16);
        bus.portA = rnd32(); bus.portB = rnd32();
        bus.storeData = 32'($urandom); bus.nPC = 32'($urandom);
        bus.dREN = 1'($urandom % 2); bus.dWEN = 1'($urandom % 2);
        bus.regWr = 1'($urandom % 2); bus.regSel = 2'($urandom % 4);
        bus.regDst = 5'($urandom % 32);
        bus.ihit = ($urandom % 8) != 0;
        bus.dhit = ($urandom % 10) == 0;
        bus.flush = ($urandom % 50) == 0;
      end else begin
        bus.ihit = ($urandom % 4) != 0;
        bus.dhit = ($urandom % 12) == 0;
        bus.flush = ($urandom % 200) == 0;
      end
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage pipeline. It sits between the decode/execute latch and the memory stage. It computes the ALU result, including a 32-cycle iterative shift-add multiply, and registers the result with pass-through control fields into the execute/memory latch that feeds the memory stage. While a multiply runs it asserts a stall to upstream stages and inserts bubbles downstream.

## Interface
- No parameters; datapath fixed at 32 bits.
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction hit; pipeline advance enable.
- dhit  in  1  data hit; the memory request in the latch is complete.
- flush  in  1  synchronous clear of the latch and the FSM.
- ALUOp  in  4  operation select.
- portA, portB  in  32  operands.
- storeData  in  32  register data for stores.
- dREN, dWEN, regWr  in  1  memory read, memory write, and register write controls.
- regSel  in  2  writeback source select.
- regDst  in  5  destination register.
- nPC  in  32  next-PC value, passed through.
- busy  out  1  stall request to upstream.
- overflow  out  1  combinational signed overflow for ADD/SUB.
- dREN_next, dWEN_next, regWr_next  out  1  latched controls.
- regSel_next  out  2; regDst_next  out  5.
- nPC_next, ALUOut_next, storeData_next  out  32  latched values.

## Operation
- ALUOp encoding:
  - 0 SLL: B << A[4:0].
  - 1 SRL: logical B >> A[4:0].
  - 2 ADD, 3 SUB: mod 2^32.
  - 4 AND, 5 OR, 6 XOR, 7 NOR.
  - 8 SLT: signed, result 1 or 0.
  - 9 SLTU: unsigned, result 1 or 0.
  - 10 MUL: low 32 bits of the unsigned product.
  - 11–15: result 0.
- overflow is 1 only for ADD/SUB when the signed result overflows; otherwise 0.
- Latch priority, identical in every FSM state unless noted: RST/flush > dhit > ihit.
  - RST or flush: all *_next outputs become 0 and the FSM goes to IDLE.
  - dhit: dREN_next = dWEN_next = 0; all other outputs and the FSM hold.
  - ihit: behaviour depends on FSM state, below.
- FSM states: IDLE, MUL, DONE. Internal state: multiplicand (64-bit), multiplier (32-bit), accumulator (64-bit), count (5-bit).
- IDLE with ihit and ALUOp ≠ 10: latch all outputs from the inputs; ALUOut_next = ALU result.
- IDLE with ihit and ALUOp = 10:
  - Load multiplicand = A, multiplier = B, accumulator = 0, count = 0.
  - Go to MUL.
  - Write a bubble: regWr_next, dREN_next, dWEN_next = 0; other outputs hold.
- MUL, each edge, regardless of ihit:
  - If multiplier[0] = 1, accumulator += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; count++.
  - When count = 31 on this edge, go to DONE.
  - Outputs keep the bubble.
- DONE with ihit: latch all outputs from the inputs, with ALUOut_next = accumulator[31:0]; go to IDLE. Without ihit: hold.
- busy = (IDLE & ihit & ALUOp = 10 & ~flush) | (state = MUL). busy is 0 in DONE.
- Upstream holds portA, portB and all control inputs stable while busy = 1.
- dhit during MUL clears dREN_next/dWEN_next only; the multiply continues.

## Timing
- Reset values:
  - All *_next outputs = 0.
  - busy = 0 (IDLE).
  - Internal registers = 0.
- Non-MUL instruction: one cycle; result visible after the ihit edge.
- MUL with continuous ihit:
  - Start edge E0 enters MUL.
  - Edges E1–E32 perform the 32 iterations.
  - E32 enters DONE.
  - E33 latches the product.
  - busy is high for the 33 cycles preceding E0–E32.
- flush on any edge during MUL or DONE aborts: outputs go to 0 and the FSM to IDLE on that edge.
- RST asserted mid-multiply forces reset values immediately, without waiting for a clock edge.
- Back-to-back MULs: the second MUL starts from IDLE on the edge after E33.

## Test plan
- Reset: RST pulsed with CLK stopped -> all outputs 0 and busy = 0 immediately.
- ADD overflow: A = 0x7FFFFFFF, B = 1, ALUOp = 2, ihit -> ALUOut_next = 0x80000000, overflow = 1. SUB with A = 5, B = 7 -> 0xFFFFFFFE, overflow = 0.
- Compare and shift:
  - A = 0xFFFFFFFF, B = 1: SLT -> 1; SLTU -> 0.
  - SLL with A = 4, B = 0x1 -> 0x10.
  - SRL with A = 31, B = 0x80000000 -> 1.
- Multiply: MUL A = 3, B = 5, regWr = 1, regDst = 9, ihit held high.
  - busy high for exactly 33 cycles.
  - regWr_next = 0 throughout.
  - After E33: ALUOut_next = 15, regWr_next = 1, regDst_next = 9.
  - Repeat with A = 0xFFFFFFFF, B = 0xFFFFFFFF -> ALUOut_next = 0x00000001.
- flush mid-multiply: flush 10 cycles after MUL start -> outputs 0, busy = 0 on the next cycle. A following ADD 2+2 -> ALUOut_next = 4.
- dhit interaction: with dREN_next = 1 latched, assert dhit during a MUL.
  - dREN_next -> 0.
  - The MUL still completes at E33 with the correct product.
  - When dhit and ihit are asserted together on an IDLE edge, dhit wins and no new capture occurs.
